spr_render: RTL and testbench

- Downstream consumer of the sprite evaluator (OAM/secondary-OAM fetch stage).
- During fetch cycles 256-319 it captures, for each of 8 sprite slots:
  - attribute and x, from the evaluator;
  - two pattern planes, from the VRAM read bus.
- During visible cycles 1-256 it counts down x per slot and shifts pattern bits out.
- It outputs the highest-priority opaque sprite pixel per dot to the pixel compositor.

---
 rtl/ppu_pkg.sv | 24 ++
 rtl/spr_slot.sv | 57 +++++
 rtl/spr_render.sv | 134 +++++++++++++
 tb/tb_spr_render.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: PPUMASK bit indices, sprite fetch window,
// per-slot sprite state record and a bit-reverse helper for horizontal flip.
package ppu_pkg;

  localparam int PPUMASK_S  = 4;
  localparam int PPUMASK_SL = 2;

  localparam logic [8:0] SPR_FETCH_START = 9'd256;
  localparam logic [8:0] SPR_FETCH_END   = 9'd319;

  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] xcnt;
    logic [7:0] plane0;
    logic [7:0] plane1;
  } spr_slot_t;

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

endpackage

// File: rtl/spr_slot.sv
// One sprite slot: latches attribute/x/pattern planes during fetch, then
// counts x down and shifts pattern bits out MSB-first during the visible dots.
module spr_slot
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load_a,
  input  logic       i_load_b,
  input  logic       i_render,
  input  logic [7:0] i_attr,
  input  logic [7:0] i_x,
  input  logic [7:0] i_pat,
  input  logic       i_empty,
  output logic [1:0] o_pat,
  output logic [1:0] o_pal,
  output logic       o_pri
);

  spr_slot_t  r_slot;
  logic       w_flip;
  logic [7:0] w_pat;

  // Plane 0 arrives with the attribute, so flip uses the live attribute there.
  assign w_flip = i_load_a ? i_attr[6] : r_slot.attr[6];
  assign w_pat  = i_empty ? 8'h00 : (w_flip ? rev8(i_pat) : i_pat);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot <= '0;
    end else begin
      if (i_load_a) begin
        r_slot.attr   <= i_attr;
        r_slot.xcnt   <= i_x;
        r_slot.plane0 <= w_pat;
      end
      if (i_load_b) r_slot.plane1 <= w_pat;
      if (i_render) begin
        if (r_slot.xcnt != 8'd0) begin
          r_slot.xcnt <= r_slot.xcnt - 8'd1;
        end else begin
          r_slot.plane0 <= {r_slot.plane0[6:0], 1'b0};
          r_slot.plane1 <= {r_slot.plane1[6:0], 1'b0};
        end
      end
    end
  end

  assign o_pat = (i_render && r_slot.xcnt == 8'd0) ?
                 {r_slot.plane1[7], r_slot.plane0[7]} : 2'b00;
  assign o_pal = r_slot.attr[1:0];
  assign o_pri = r_slot.attr[5];

  logic w_unused_attr;
  assign w_unused_attr = ^{r_slot.attr[7], r_slot.attr[4:2]};

endmodule

// File: rtl/spr_render.sv
// Sprite renderer: NSLOT slots plus priority mux, clipping and sprite-0 hit.
// Sprite-0 hit output is only generated when SPR_SP0_HIT_EN is defined.
module spr_render
  import ppu_pkg::*;
#(
  parameter int NSLOT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rend,
  input  logic [8:0] cycle,
  input  logic [7:0] ppumask,
  input  logic [7:0] attribute,
  input  logic [7:0] x,
  input  logic       sp_empty,
  input  logic       sp0,
  input  logic [7:0] pat_data,
  input  logic       bg_opaque,
  output logic [3:0] sp_pix,
  output logic       sp_pri,
  output logic       sp_is0,
  output logic       sp0_hit_set
);

  logic                  w_load;
  logic                  w_render;
  logic [2:0]            w_slot;
  logic [2:0]            w_c8;
  logic [7:0]            w_px;
  logic                  w_clip;
  logic [NSLOT-1:0][1:0] w_pat;
  logic [NSLOT-1:0][1:0] w_pal;
  logic [NSLOT-1:0]      w_pri;
  logic [1:0]            w_win_pat;
  logic [1:0]            w_win_pal;
  logic                  w_win_pri;
  logic                  w_win_is0;
  logic                  r_is0;
  logic [3:0]            r_sp_pix;
  logic                  r_sp_pri;
  logic                  r_sp_is0;

  assign w_load   = rend && cycle >= SPR_FETCH_START && cycle <= SPR_FETCH_END;
  assign w_render = rend && cycle >= 9'd1 && cycle <= 9'd256;
  assign w_slot   = cycle[5:3];
  assign w_c8     = cycle[2:0];
  assign w_px     = cycle[7:0] - 8'd1;
  assign w_clip   = !ppumask[PPUMASK_S] || (!ppumask[PPUMASK_SL] && w_px < 8'd8);

  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      spr_slot u_slot (
        .clk      (clk),
        .rst      (rst),
        .i_load_a (w_load && w_slot == 3'(gi) && w_c8 == 3'd5),
        .i_load_b (w_load && w_slot == 3'(gi) && w_c8 == 3'd7),
        .i_render (w_render),
        .i_attr   (attribute),
        .i_x      (x),
        .i_pat    (pat_data),
        .i_empty  (sp_empty),
        .o_pat    (w_pat[gi]),
        .o_pal    (w_pal[gi]),
        .o_pri    (w_pri[gi])
      );
    end
  endgenerate

  // Scan from the highest slot down so the lowest opaque slot overrides.
  always_comb begin
    w_win_pat = 2'b00;
    w_win_pal = 2'b00;
    w_win_pri = 1'b0;
    w_win_is0 = 1'b0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (w_pat[i] != 2'b00) begin
        w_win_pat = w_pat[i];
        w_win_pal = w_pal[i];
        w_win_pri = w_pri[i];
        w_win_is0 = (i == 0) && r_is0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is0 <= 1'b0;
    end else if (rend && cycle == SPR_FETCH_END) begin
      r_is0 <= sp0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !w_render || w_clip || w_win_pat == 2'b00) begin
      r_sp_pix <= 4'd0;
      r_sp_pri <= 1'b0;
      r_sp_is0 <= 1'b0;
    end else begin
      r_sp_pix <= {w_win_pal, w_win_pat};
      r_sp_pri <= w_win_pri;
      r_sp_is0 <= w_win_is0;
    end
  end

  assign sp_pix = r_sp_pix;
  assign sp_pri = r_sp_pri;
  assign sp_is0 = r_sp_is0;

`ifdef SPR_SP0_HIT_EN
  logic [7:0] r_px_d;
  logic       r_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_px_d <= 8'd0;
      r_hit  <= 1'b0;
    end else begin
      r_px_d <= w_px;
      r_hit  <= r_sp_is0 && r_sp_pix[1:0] != 2'b00 && bg_opaque && r_px_d != 8'hFF;
    end
  end

  assign sp0_hit_set = r_hit;

  logic w_unused_mask;
  assign w_unused_mask = ^{ppumask[7:5], ppumask[3], ppumask[1:0]};
`else
  assign sp0_hit_set = 1'b0;

  logic w_unused_mask;
  assign w_unused_mask = ^{ppumask[7:5], ppumask[3], ppumask[1:0], bg_opaque};
`endif

endmodule

// File: tb/tb_spr_render.sv
// Scanline-level bench for spr_render: a pixel-level reference model pushes
// expected dots into a scoreboard that is popped as each registered dot appears.
module tb_spr_render;

`ifdef SPR_SP0_HIT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rend;
  logic [8:0] cycle;
  logic [7:0] ppumask;
  logic [7:0] attribute;
  logic [7:0] x;
  logic       sp_empty;
  logic       sp0;
  logic [7:0] pat_data;
  logic       bg_opaque;
  logic [3:0] sp_pix;
  logic       sp_pri;
  logic       sp_is0;
  logic       sp0_hit_set;

  always #5 clk = ~clk;

  spr_render dut (
    .clk         (clk),
    .rst         (rst),
    .rend        (rend),
    .cycle       (cycle),
    .ppumask     (ppumask),
    .attribute   (attribute),
    .x           (x),
    .sp_empty    (sp_empty),
    .sp0         (sp0),
    .pat_data    (pat_data),
    .bg_opaque   (bg_opaque),
    .sp_pix      (sp_pix),
    .sp_pri      (sp_pri),
    .sp_is0      (sp_is0),
    .sp0_hit_set (sp0_hit_set)
  );

  typedef struct {
    logic [3:0] pix;
    logic       pri;
    logic       is0;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hit_cnt;
  int   hit_cyc;

  // Stimulus config for the next load, and the model of what the DUT holds.
  logic [7:0] cfg_attr[8], cfg_x[8], cfg_p0[8], cfg_p1[8];
  bit         cfg_empty[8];
  bit         cfg_sp0;
  logic [7:0] m_attr[8], m_x[8], m_p0[8], m_p1[8];
  bit         m_empty[8];
  bit         m_sp0;

  function automatic exp_t model(int px);
    exp_t e;
    bit   found;
    e = '{4'd0, 1'b0, 1'b0};
    found = 1'b0;
    for (int s = 0; s < 8; s++) begin
      int off;
      int bp;
      logic [1:0] p;
      off = px - int'(m_x[s]);
      if (!found && !m_empty[s] && off >= 0 && off < 8) begin
        bp = m_attr[s][6] ? off : 7 - off;
        p  = {m_p1[s][bp], m_p0[s][bp]};
        if (p != 2'b00) begin
          found = 1'b1;
          e.pix = {m_attr[s][1:0], p};
          e.pri = m_attr[s][5];
          e.is0 = (s == 0) && m_sp0;
        end
      end
    end
    if (!ppumask[4] || (!ppumask[2] && px < 8)) e = '{4'd0, 1'b0, 1'b0};
    return e;
  endfunction

  task automatic clear_cfg();
    for (int s = 0; s < 8; s++) begin
      cfg_attr[s] = 8'h00; cfg_x[s] = 8'hFF; cfg_p0[s] = 8'h00; cfg_p1[s] = 8'h00;
      cfg_empty[s] = 1'b1;
    end
    cfg_sp0 = 1'b0;
  endtask

  // bg_at: -1 = background opaque all line, -2 = never, else one cycle only.
  task automatic run_line(input int rst_at, input int bg_at, input bit rend_v);
    hit_cnt = 0;
    hit_cyc = -1;
    for (int c = 0; c < 341; c++) begin
      exp_t e;
      int   s;
      cycle     = c[8:0];
      rend      = rend_v;
      rst       = (c == rst_at);
      bg_opaque = (bg_at == -1) || (c == bg_at);
      if (c >= 256 && c <= 319) begin
        s         = c / 8 - 32;
        attribute = cfg_attr[s];
        x         = cfg_x[s];
        sp_empty  = cfg_empty[s];
        pat_data  = (c % 8 == 7) ? cfg_p1[s] : cfg_p0[s];
      end else begin
        attribute = 8'($urandom);
        x         = 8'($urandom);
        sp_empty  = 1'($urandom);
        pat_data  = 8'($urandom);
      end
      sp0 = (c == 319) ? cfg_sp0 : 1'($urandom);
      if (c == rst_at) begin
        for (int k = 0; k < 8; k++) begin
          m_attr[k] = 8'h00; m_x[k] = 8'h00; m_p0[k] = 8'h00; m_p1[k] = 8'h00;
          m_empty[k] = 1'b0;
        end
        m_sp0 = 1'b0;
      end
      if (rend_v && c >= 1 && c <= 256) e = model(c - 1);
      else e = '{4'd0, 1'b0, 1'b0};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (sp_pix !== e.pix) begin
        errors++;
        $display("FAIL sp_pix cycle=%0d got %h expected %h", c, sp_pix, e.pix);
      end
      if (e.pix != 4'd0) begin
        checks++;
        if ({sp_pri, sp_is0} !== {e.pri, e.is0}) begin
          errors++;
          $display("FAIL pri_is0 cycle=%0d got %b%b expected %b%b",
                   c, sp_pri, sp_is0, e.pri, e.is0);
        end
      end
      if (sp0_hit_set === 1'b1) begin
        hit_cnt++;
        hit_cyc = c;
      end
    end
    rst = 1'b0;
    if (rend_v) begin
      for (int k = 0; k < 8; k++) begin
        m_attr[k] = cfg_attr[k]; m_x[k] = cfg_x[k];
        m_p0[k] = cfg_p0[k]; m_p1[k] = cfg_p1[k]; m_empty[k] = cfg_empty[k];
      end
      m_sp0 = cfg_sp0;
    end
    $display("line rend=%0d rst_at=%0d bg_at=%0d hits=%0d checks=%0d errors=%0d",
             rend_v, rst_at, bg_at, hit_cnt, checks, errors);
  endtask

  task automatic test_reset();
    rst = 1'b1; rend = 1'b1; cycle = 9'd100; ppumask = 8'h1E;
    attribute = 8'h00; x = 8'h00; sp_empty = 1'b0; sp0 = 1'b1;
    pat_data = 8'hFF; bg_opaque = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sp_pix, sp_pri, sp_is0, sp0_hit_set} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 0000000",
               {sp_pix, sp_pri, sp_is0, sp0_hit_set});
    end
    for (int k = 0; k < 8; k++) begin
      m_attr[k] = 8'h00; m_x[k] = 8'h00; m_p0[k] = 8'h00; m_p1[k] = 8'h00;
      m_empty[k] = 1'b0;
    end
    m_sp0 = 1'b0;
    rst = 1'b0;
    $display("reset checked pix=%h", sp_pix);
  endtask

  task automatic test_basic();
    clear_cfg();
    ppumask = 8'h1E;
    cfg_attr[0] = 8'h01; cfg_x[0] = 8'h10; cfg_p0[0] = 8'hFF; cfg_p1[0] = 8'h00;
    cfg_empty[0] = 1'b0;
    run_line(-1, -2, 1'b1);
    run_line(-1, -2, 1'b1);
  endtask

  task automatic test_flip();
    clear_cfg();
    cfg_attr[0] = 8'h41; cfg_x[0] = 8'h10; cfg_p0[0] = 8'h80; cfg_p1[0] = 8'h00;
    cfg_empty[0] = 1'b0;
    run_line(-1, -2, 1'b1);
    run_line(-1, -2, 1'b1);
  endtask

  task automatic test_priority();
    clear_cfg();
    cfg_attr[2] = 8'h22; cfg_x[2] = 8'd5; cfg_p0[2] = 8'hFF; cfg_empty[2] = 1'b0;
    cfg_attr[5] = 8'h03; cfg_x[5] = 8'd5; cfg_p0[5] = 8'hFF; cfg_p1[5] = 8'hF0;
    cfg_empty[5] = 1'b0;
    cfg_attr[6] = 8'h01; cfg_x[6] = 8'd9; cfg_p1[6] = 8'hFF; cfg_empty[6] = 1'b0;
    run_line(-1, -2, 1'b1);
    run_line(-1, -2, 1'b1);
  endtask

  task automatic test_clip();
    clear_cfg();
    cfg_attr[0] = 8'h00; cfg_x[0] = 8'd0; cfg_p0[0] = 8'hFF; cfg_p1[0] = 8'hFF;
    cfg_empty[0] = 1'b0;
    cfg_attr[3] = 8'h02; cfg_x[3] = 8'd250; cfg_p0[3] = 8'hFF; cfg_empty[3] = 1'b0;
    ppumask = 8'h1A;
    run_line(-1, -2, 1'b1);
    run_line(-1, -2, 1'b1);
    ppumask = 8'h1E;
    run_line(-1, -2, 1'b1);
    ppumask = 8'h0E;
    run_line(-1, -2, 1'b1);
    ppumask = 8'h1E;
  endtask

  task automatic test_sp0_hit();
    clear_cfg();
    cfg_attr[0] = 8'h00; cfg_x[0] = 8'd100; cfg_p0[0] = 8'hFF; cfg_empty[0] = 1'b0;
    cfg_sp0 = 1'b1;
    run_line(-1, -2, 1'b1);
    run_line(-1, 104, 1'b1);
    checks++;
    if (hit_cnt != (HIT_EN ? 1 : 0)) begin
      errors++;
      $display("FAIL sp0_hit_count got %0d expected %0d", hit_cnt, HIT_EN ? 1 : 0);
    end
    if (HIT_EN) begin
      checks++;
      if (hit_cyc != 104) begin
        errors++;
        $display("FAIL sp0_hit_cycle got %0d expected 104", hit_cyc);
      end
    end
    cfg_x[0] = 8'd255;
    run_line(-1, -2, 1'b1);
    run_line(-1, -1, 1'b1);
    checks++;
    if (hit_cnt != 0) begin
      errors++;
      $display("FAIL sp0_hit_px255 got %0d expected 0", hit_cnt);
    end
  endtask

  task automatic test_empty_reset();
    clear_cfg();
    for (int s = 0; s < 8; s++) begin
      cfg_x[s] = 8'd10; cfg_p0[s] = 8'hFF; cfg_p1[s] = 8'hFF; cfg_attr[s] = 8'h03;
    end
    run_line(-1, -2, 1'b1);
    run_line(-1, -2, 1'b1);
    clear_cfg();
    cfg_attr[0] = 8'h03; cfg_x[0] = 8'd150; cfg_p0[0] = 8'hFF; cfg_empty[0] = 1'b0;
    run_line(-1, -2, 1'b1);
    run_line(130, -2, 1'b1);
    checks++;
    if (sp_is0 !== 1'b0) begin
      errors++;
      $display("FAIL is0_after_reset got %b expected 0", sp_is0);
    end
    run_line(-1, -2, 1'b1);
  endtask

  task automatic test_rend_off();
    clear_cfg();
    cfg_attr[1] = 8'h03; cfg_x[1] = 8'd40; cfg_p0[1] = 8'h0F; cfg_p1[1] = 8'hF0;
    cfg_empty[1] = 1'b0;
    run_line(-1, -2, 1'b1);
    cfg_x[1] = 8'd200;
    run_line(-1, -2, 1'b0);
    run_line(-1, -2, 1'b1);
    run_line(-1, -2, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flip();
    test_priority();
    test_clip();
    test_sp0_hit();
    test_empty_reset();
    test_rend_off();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
